sel_mux_pipe: RTL
=================

// Module: sel_mux_pipe
// PURPOSE
//  Parametrised N-to-1 select mux with one registered output stage and a
//  valid/ready handshake. A 2-entry skid buffer gives full throughput.
//  Used wherever the datapath mux must sit on a pipeline boundary, e.g.
//  the ALU source selects and the register-file write-back select.
//  Out-of-range selects are flagged rather than silently aliased.
// PARAMETERS
//  WIDTH    32  data width of each input and of the output
//  NUM_IN   4   number of inputs, 2..16
//  SEL_W    $clog2(NUM_IN)  select width (derived; do not override)
// PORTS
//  CLK        in   1              rising-edge clock
//  RST_N      in   1              asynchronous, active-low reset
//  IN_DATA    in   NUM_IN*WIDTH   flat inputs; input k = IN_DATA[k*WIDTH +: WIDTH]
//  SEL        in   SEL_W          input index, sampled with IN_DATA
//  IN_VALID   in   1              upstream offers IN_DATA/SEL this cycle
//  IN_READY   out  1              block accepts this cycle; registered
//  OUT_DATA   out  WIDTH          selected word
//  OUT_SEL    out  SEL_W          SEL value that produced OUT_DATA
//  OUT_ERR    out  1              SEL was >= NUM_IN; OUT_DATA is 0
//  OUT_VALID  out  1              OUT_* holds a valid word
//  OUT_READY  in   1              downstream consumes OUT_* this cycle
// BEHAVIOUR
//  - Transfer in: IN_VALID & IN_READY at a rising CLK edge.
//    Transfer out: OUT_VALID & OUT_READY at a rising CLK edge.
//  - Select: word = IN_DATA[SEL*WIDTH +: WIDTH] when SEL < NUM_IN.
//    Otherwise word = 0 and err = 1. An out-of-range SEL is possible
//    only when NUM_IN is not a power of 2. The word, SEL and err travel
//    together.
//  - Storage: main register (drives OUT_*) plus one skid register.
//  - States: EMPTY (main invalid), ONE (main valid, skid empty),
//    TWO (main and skid both valid).
//    * EMPTY + in-transfer -> ONE; main <= new word.
//    * ONE + in-transfer + out-transfer -> ONE; main <= new word.
//    * ONE + in-transfer, no out-transfer -> TWO; skid <= new word.
//    * ONE + out-transfer, no in-transfer -> EMPTY.
//    * TWO + out-transfer -> ONE; main <= skid. No in-transfer is
//      possible here because IN_READY = 0.
//    * Any other case holds state and all registers.
//  - IN_READY = 1 in EMPTY and ONE, 0 in TWO. It is a flop output; there
//    is no combinational path from OUT_READY to IN_READY.
//  - Latency: a word accepted at edge n appears on OUT_* after edge n,
//    when the block was EMPTY or ONE with an out-transfer at edge n.
//  - Ordering: strictly FIFO. There is no loss or duplication under any
//    IN_VALID/OUT_READY pattern.
//  - OUT_* stays stable while OUT_VALID = 1 and OUT_READY = 0.
//  - Upstream must hold IN_DATA/SEL stable while IN_VALID = 1 and
//    IN_READY = 0. The block does not check this.
//  - Reset (RST_N = 0, asynchronous, at any time, including mid-transfer):
//    state -> EMPTY, OUT_VALID = 0, OUT_DATA = 0, OUT_SEL = 0,
//    OUT_ERR = 0, skid cleared, IN_READY = 1. In-flight words are
//    discarded. No transfer happens on the first edge with RST_N = 0.
//  - Deassertion of RST_N is synchronised by the system. Transfers may
//    begin on the first edge after deassertion.
// TESTING
//  1. Reset: drive RST_N = 0 mid-stream with OUT_VALID = 1 ->
//     OUT_VALID = 0, OUT_DATA = 0, IN_READY = 1 immediately, before any
//     clock edge.
//  2. Select sweep (NUM_IN = 4, WIDTH = 32): inputs 0xA0..0xA3,
//     SEL = 0..3 back-to-back, OUT_READY = 1 -> OUT_DATA = 0xA0..0xA3 one
//     cycle later each, OUT_SEL matches, OUT_ERR = 0.
//  3. Back-pressure: OUT_READY = 0 while pushing 0x11, 0x22 ->
//     IN_READY = 0 after the second push, and 0x33 is held.
//     Raise OUT_READY -> output 0x11, 0x22, 0x33 in order, none lost.
//  4. Out-of-range (NUM_IN = 3, SEL = 3) -> OUT_DATA = 0, OUT_ERR = 1,
//     OUT_SEL = 3. The next word with SEL = 1 has OUT_ERR = 0.
//  5. Random IN_VALID and OUT_READY toggling, 10k cycles, NUM_IN = 5 and
//     16 -> scoreboard matches in order, OUT_* stable under stall, and
//     full throughput whenever OUT_READY = 1.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// rtl/sel_mux_pipe.sv - N-to-1 select mux on a registered valid/ready boundary with a 2-entry skid buffer
`timescale 1ns/1ps

module sel_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    out_err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   main_data_q;
  logic [SEL_W-1:0]   main_sel_q;
  logic               main_err_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic [SEL_W-1:0]   skid_sel_q;
  logic               skid_err_q;

  logic [WIDTH-1:0]   word_d;
  logic               err_d;

  // A select with no matching input yields a zero word flagged as an error,
  // so non-power-of-2 configurations never alias onto a real input.
  always_comb begin
    word_d = '0;
    err_d  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        word_d = in_data_i[k*WIDTH +: WIDTH];
        err_d  = 1'b0;
      end
    end
  end

  // in_ready_q and out_valid_q track the state so both handshake outputs
  // come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid_i) begin
            main_data_q <= word_d;
            main_sel_q  <= sel_i;
            main_err_q  <= err_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_valid_i && out_ready_i) begin
            main_data_q <= word_d;
            main_sel_q  <= sel_i;
            main_err_q  <= err_d;
          end else if (in_valid_i) begin
            skid_data_q <= word_d;
            skid_sel_q  <= sel_i;
            skid_err_q  <= err_d;
            state_q     <= TWO;
            in_ready_q  <= 1'b0;
          end else if (out_ready_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (out_ready_i) begin
            main_data_q <= skid_data_q;
            main_sel_q  <= skid_sel_q;
            main_err_q  <= skid_err_q;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  assign out_sel_o   = main_sel_q;
  assign out_err_o   = main_err_q;

endmodule
